write_buffer: RTL

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/wb_pkg.sv | 18 +
 rtl/write_buffer_match.sv | 42 ++++
 rtl/write_buffer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the cache-to-RAM write buffer.
//   WB_XLEN          : address/data width the entry type is built for
//   WB_DEPTH_DEFAULT : default number of buffer entries
//   wb_entry_t       : one buffered write, word address plus data
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_XLEN          = 32;
    localparam int WB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [WB_XLEN-3:0] addr;   // word address, byte offset dropped
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/write_buffer_match.sv
// -----------------------------------------------------------------------------
// write_buffer_match
// Compares a read word address against every valid buffer entry and returns
// the data of the youngest matching entry.
//   entries  : entry storage, indexed by FIFO slot
//   valid    : per-slot valid flags
//   head     : slot of the oldest entry
//   rd_word  : read word address (c_addr[XLEN-1:2])
//   hit      : at least one valid entry matches
//   hit_data : data of the youngest matching entry, 0 when no hit
// -----------------------------------------------------------------------------
module write_buffer_match
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t          entries [DEPTH],
    input  logic [DEPTH-1:0]   valid,
    input  logic [PTR_W-1:0]   head,
    input  logic [WB_XLEN-3:0] rd_word,
    output logic               hit,
    output logic [WB_XLEN-1:0] hit_data
);

    // Walk slots from oldest to youngest; a later match overrides an earlier
    // one, so the last writer to an address wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && (entries[idx].addr == rd_word)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/write_buffer.sv
// -----------------------------------------------------------------------------
// write_buffer
// Circular FIFO that absorbs cache eviction writes and drains them to RAM,
// with read-after-write hazard detection on cache miss reads.
//   clk, rst          : clock, synchronous active-high reset
//   c_wr_en/c_addr/c_wd : eviction write request from the cache
//   c_rd              : read data back to the cache
//   c_stall           : cache must hold its request this cycle
//   m_waddr/m_wd/m_we : write presented to RAM, m_ready accepts it
//   m_raddr/m_rd      : RAM read port (m_rd combinational from m_raddr)
// Build option:
//   WB_FORWARD_EN     : forward buffered data on a read hazard instead of
//                       stalling until the matching entries have drained
// -----------------------------------------------------------------------------
module write_buffer
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            c_wr_en,
    input  logic [XLEN-1:0] c_addr,
    input  logic [XLEN-1:0] c_wd,
    output logic [XLEN-1:0] c_rd,
    output logic            c_stall,
    output logic [XLEN-1:0] m_waddr,
    output logic [XLEN-1:0] m_wd,
    output logic            m_we,
    input  logic            m_ready,
    output logic [XLEN-1:0] m_raddr,
    input  logic [XLEN-1:0] m_rd
);

    localparam int PTR_W = $clog2(DEPTH);

    // The entry type is fixed by the package, so the port width must agree.
    if (XLEN != WB_XLEN) begin : g_xlen_check
        $error("write_buffer: XLEN must equal wb_pkg::WB_XLEN");
    end

    wb_entry_t        entries_q [DEPTH];
    wb_entry_t        entries_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             full, empty, enq, pop;
    logic             hit, rd_hazard;
    logic [XLEN-1:0]  fwd_data;
    wb_entry_t        head_e;

    assign full   = (count_q == (PTR_W+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign head_e = entries_q[head_q];

    // Outputs are gated by rst so the RAM and cache see an idle buffer for
    // the whole reset window, not just after the first reset edge.
    assign m_we    = !rst && !empty;
    assign m_waddr = m_we ? {head_e.addr, 2'b00} : '0;
    assign m_wd    = m_we ? head_e.data : '0;
    assign m_raddr = c_addr;

    // A full buffer blocks the enqueue even if the head pops this same edge.
    assign enq = c_wr_en && !full;
    assign pop = m_we && m_ready;

    write_buffer_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .entries  (entries_q),
        .valid    (valid_q),
        .head     (head_q),
        .rd_word  (c_addr[XLEN-1:2]),
        .hit      (hit),
        .hit_data (fwd_data)
    );

    assign rd_hazard = !rst && !c_wr_en && hit;

`ifdef WB_FORWARD_EN
    assign c_rd    = rd_hazard ? fwd_data : m_rd;
    assign c_stall = !rst && c_wr_en && full;
`else
    logic fwd_unused;
    assign fwd_unused = ^fwd_data;
    assign c_rd    = m_rd;
    assign c_stall = !rst && ((c_wr_en && full) || rd_hazard);
`endif

    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (enq) begin
            entries_d[tail_q].addr = c_addr[XLEN-1:2];
            entries_d[tail_q].data = c_wd;
            valid_d[tail_q]        = 1'b1;
            tail_d                 = tail_q + 1'b1;
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset; valid flags qualify it.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

endmodule
